// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter stage feeding fetch. Each cycle it presents the address of
//   the next instruction word. It supports sequential increment, absolute and
//   conditional jumps, subroutine call/return through a small hardware return
//   stack, and a RUN / HALT / ERROR state machine.
//
// Ports
//   clk_pc_i     clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset, overrides every other input
//   step_i       advance enable; when low, RUN state holds and strobes are dropped
//   jmp_i        unconditional jump to jmp_addr_i
//   jmp_c_i      conditional jump to jmp_addr_i, taken when cond_i is high
//   cond_i       condition flag from the ALU
//   call_i       push p_count+1, then jump to jmp_addr_i
//   ret_i        pop the return address into p_count
//   hlt_i        request halt
//   resume_i     leave HALT (ERROR is only left through reset)
//   jmp_addr_i   jump/call target
//   p_count_o    current fetch address (registered)
//   halted_o     high in HALT or ERROR (registered)
//   stk_err_o    sticky stack overflow/underflow flag (registered)
//   sp_o         return-stack occupancy, 0..STK_DEPTH (registered)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned          ADDR_W    = 8,
    parameter int unsigned          STK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]    RST_ADDR  = '0
) (
    input  logic                            clk_pc_i,
    input  logic                            reset_i,
    input  logic                            step_i,
    input  logic                            jmp_i,
    input  logic                            jmp_c_i,
    input  logic                            cond_i,
    input  logic                            call_i,
    input  logic                            ret_i,
    input  logic                            hlt_i,
    input  logic                            resume_i,
    input  logic [ADDR_W-1:0]               jmp_addr_i,
    output logic [ADDR_W-1:0]               p_count_o,
    output logic                            halted_o,
    output logic                            stk_err_o,
    output logic [$clog2(STK_DEPTH):0]      sp_o
);

    localparam int unsigned IDX_W = $clog2(STK_DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [SP_W-1:0]        sp_q, sp_d;
    logic                   err_q, err_d;
    logic                   halted_q, halted_d;

    logic [ADDR_W-1:0]      stack_q [STK_DEPTH];

    logic                   push_en;
    logic [IDX_W-1:0]       push_idx;
    logic [ADDR_W-1:0]      push_addr;
    logic [IDX_W-1:0]       top_idx;
    logic [ADDR_W-1:0]      pc_inc;
    logic                   stk_empty;
    logic                   stk_full;

    // Shared address arithmetic and stack status.
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign top_idx   = IDX_W'(sp_q - SP_W'(1));
    assign stk_empty = (sp_q == '0);
    assign stk_full  = (sp_q == SP_W'(STK_DEPTH));

    // State register and output registers.
    always_ff @(posedge clk_pc_i) begin
        if (reset_i) begin
            state_q  <= ST_RUN;
            pc_q     <= RST_ADDR;
            sp_q     <= '0;
            err_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            err_q    <= err_d;
            halted_q <= halted_d;
        end
    end

    // Return-stack storage; contents are don't-care after reset since sp gates use.
    always_ff @(posedge clk_pc_i) begin
        if (!reset_i && push_en) begin
            stack_q[push_idx] <= push_addr;
        end
    end

    // Next-state logic: one winning action per cycle, highest priority first.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        err_d     = err_q;
        push_en   = 1'b0;
        push_idx  = IDX_W'(sp_q);
        push_addr = pc_inc;

        unique case (state_q)
            ST_RUN: begin
                if (step_i) begin
                    if (hlt_i) begin
                        state_d = ST_HALT;
                    end else if (ret_i) begin
                        if (stk_empty) begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                        end else begin
                            pc_d = stack_q[top_idx];
                            sp_d = sp_q - SP_W'(1);
                        end
                    end else if (call_i) begin
                        if (stk_full) begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SP_W'(1);
                            pc_d    = jmp_addr_i;
                        end
                    end else if (jmp_i || (jmp_c_i && cond_i)) begin
                        pc_d = jmp_addr_i;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            ST_HALT: begin
                // Resume does not advance; the next step refetches the held address.
                if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
                err_d   = 1'b1;
            end
        endcase

        halted_d = (state_d != ST_RUN);
    end

    assign p_count_o = pc_q;
    assign halted_o  = halted_q;
    assign stk_err_o = err_q;
    assign sp_o      = sp_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed scenarios followed by a randomized run, all compared each cycle
//   against a behavioural model that keeps the return stack as a queue.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset, step, jmp, jmp_c, cond, call, ret, hlt, resume;
    logic [7:0] jmp_addr;
    logic [7:0] p_count;
    logic       halted, stk_err;
    logic [2:0] sp;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: 0 = running, 1 = halted, 2 = error.
    int         m_state;
    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    logic       m_err;

    pc_sequencer #(.ADDR_W(8), .STK_DEPTH(4), .RST_ADDR(8'h00)) dut (
        .clk_pc_i   (clk),
        .reset_i    (reset),
        .step_i     (step),
        .jmp_i      (jmp),
        .jmp_c_i    (jmp_c),
        .cond_i     (cond),
        .call_i     (call),
        .ret_i      (ret),
        .hlt_i      (hlt),
        .resume_i   (resume),
        .jmp_addr_i (jmp_addr),
        .p_count_o  (p_count),
        .halted_o   (halted),
        .stk_err_o  (stk_err),
        .sp_o       (sp)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        if (reset) begin
            m_pc = 8'h00; m_stk.delete(); m_state = 0; m_err = 1'b0;
        end else if (m_state == 0) begin
            if (step) begin
                if (hlt) m_state = 1;
                else if (ret) begin
                    if (m_stk.size() == 0) begin m_state = 2; m_err = 1'b1; end
                    else m_pc = m_stk.pop_back();
                end else if (call) begin
                    if (m_stk.size() == 4) begin m_state = 2; m_err = 1'b1; end
                    else begin m_stk.push_back(m_pc + 8'd1); m_pc = jmp_addr; end
                end else if (jmp || (jmp_c && cond)) m_pc = jmp_addr;
                else m_pc = m_pc + 8'd1;
            end
        end else if (m_state == 1) begin
            if (resume) m_state = 0;
        end
    endtask

    task automatic check(input string tag);
        n_assert++;
        assert (p_count === m_pc) else begin
            n_fail++; $error("FAIL %s p_count: observed %0h expected %0h", tag, p_count, m_pc);
        end
        n_assert++;
        assert (halted === (m_state != 0)) else begin
            n_fail++; $error("FAIL %s halted: observed %0b expected %0b", tag, halted, m_state != 0);
        end
        n_assert++;
        assert (sp === 3'(m_stk.size())) else begin
            n_fail++; $error("FAIL %s sp: observed %0d expected %0d", tag, sp, m_stk.size());
        end
        n_assert++;
        assert (stk_err === m_err) else begin
            n_fail++; $error("FAIL %s stk_err: observed %0b expected %0b", tag, stk_err, m_err);
        end
    endtask

    // Apply one cycle of inputs, advance the model, and compare after the edge.
    task automatic cyc(input string tag, input logic r, input logic s, input logic j,
                       input logic jc, input logic c, input logic cl, input logic rt,
                       input logic h, input logic rs, input logic [7:0] a);
        reset = r; step = s; jmp = j; jmp_c = jc; cond = c;
        call = cl; ret = rt; hlt = h; resume = rs; jmp_addr = a;
        @(posedge clk);
        model_update();
        #1;
        check(tag);
    endtask

    // Common shorthands.
    task automatic do_reset(input string tag);
        cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask
    task automatic do_step(input string tag);
        cyc(tag, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    endtask
    task automatic do_jmp(input string tag, input logic [7:0] a);
        cyc(tag, 0, 1, 1, 0, 0, 0, 0, 0, 0, a);
    endtask
    task automatic do_call(input string tag, input logic [7:0] a);
        cyc(tag, 0, 1, 0, 0, 0, 1, 0, 0, 0, a);
    endtask
    task automatic do_ret(input string tag);
        cyc(tag, 0, 1, 0, 0, 0, 0, 1, 0, 0, 8'h00);
    endtask

    initial begin
        m_state = 0; m_pc = 8'h00; m_err = 1'b0;
        reset = 1; step = 0; jmp = 0; jmp_c = 0; cond = 0;
        call = 0; ret = 0; hlt = 0; resume = 0; jmp_addr = 8'h00;

        // 1: reset then 20 sequential steps
        do_reset("reset");
        for (int i = 0; i < 20; i++) do_step("seq");

        // 2: wrap from FF to 00
        do_jmp("jmp_fe", 8'hFE);
        for (int i = 0; i < 4; i++) do_step("wrap");

        // 3: call/return round trip
        do_jmp("jmp_10", 8'h10);
        do_call("call_40", 8'h40);
        do_step("sub_step");
        do_step("sub_step");
        do_ret("ret_11");

        // 4: overflow after four nested calls, resume ignored, reset clears
        do_call("nest1", 8'h50);
        do_call("nest2", 8'h60);
        do_call("nest3", 8'h70);
        do_call("nest4", 8'hFF);
        do_call("overflow", 8'h90);
        cyc("resume_err", 0, 1, 0, 0, 0, 0, 0, 0, 1, 8'h00);
        do_step("err_hold");
        do_reset("reset_err");
        do_ret("underflow");
        do_step("err_hold2");
        do_reset("reset_err2");

        // 4b: return address wraps when calling from FF
        do_jmp("jmp_ff", 8'hFF);
        do_call("call_wrap", 8'h33);
        do_ret("ret_wrap");

        // 5: conditional jump and jump+call priority
        do_jmp("jmp_20", 8'h20);
        cyc("jc_not", 0, 1, 0, 1, 0, 0, 0, 0, 0, 8'h80);
        cyc("jc_take", 0, 1, 0, 1, 1, 0, 0, 0, 0, 8'h80);
        cyc("jmp_call", 0, 1, 1, 0, 0, 1, 0, 0, 0, 8'hA0);
        do_ret("ret_after_jc");

        // 6: halt, hold, resume, stall, reset mid-halt
        do_jmp("jmp_05", 8'h05);
        cyc("hlt", 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 10; i++) cyc("halt_hold", 0, 1, 1, 0, 0, 1, 0, 1, 0, 8'h77);
        cyc("hlt_resume", 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h00);
        do_step("after_resume");
        cyc("stall_jmp", 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'hC0);
        cyc("stall_call", 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'hC0);
        cyc("hlt2", 0, 1, 0, 0, 0, 0, 0, 1, 0, 8'h00);
        do_reset("reset_halt");
        do_step("post_reset");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc("random",
                logic'($urandom_range(99) < 2),
                logic'($urandom_range(99) < 80),
                logic'($urandom_range(99) < 12),
                logic'($urandom_range(99) < 15),
                logic'($urandom_range(1)),
                logic'($urandom_range(99) < 18),
                logic'($urandom_range(99) < 15),
                logic'($urandom_range(99) < 5),
                logic'($urandom_range(99) < 25),
                8'($urandom_range(255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
